result_demux: RTL

//  Registered 1-to-2 demultiplexer: the inverse of the datapath 8-bit 2:1 select.

---
 rtl/result_demux_if.sv | 30 +++
 rtl/result_demux.sv | 65 ++++++
 2 files changed

// File: rtl/result_demux_if.sv
// rtl/result_demux_if.sv - result steering bus: one input handshake, two destination drains
interface result_demux_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_sel;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic [CW-1:0]    a_count;
  logic [CW-1:0]    b_count;

  modport master (
    output in_valid, in_sel, in_data, a_ready, b_ready,
    input  in_ready, a_valid, a_data, b_valid, b_data, a_count, b_count
  );

  modport slave (
    input  in_valid, in_sel, in_data, a_ready, b_ready,
    output in_ready, a_valid, a_data, b_valid, b_data, a_count, b_count
  );
endinterface

// File: rtl/result_demux.sv
// rtl/result_demux.sv - registered 1-to-2 demux into two independent per-destination FIFOs
module result_demux #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input logic           clk,
  input logic           reset,
  result_demux_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Index 0 is destination A (register-file write-back), 1 is destination B.
  logic [WIDTH-1:0] mem    [2][DEPTH];
  logic [PW-1:0]    wr_ptr [2];
  logic [PW-1:0]    rd_ptr [2];
  logic [CW-1:0]    count  [2];
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       valid;
  logic             in_ready;

  // Full check uses registered counts only, so a same-cycle pop never admits a push.
  assign in_ready = !reset && (bus.in_sel ? (count[1] != FULL) : (count[0] != FULL));

  assign push[0] = bus.in_valid && in_ready && !bus.in_sel;
  assign push[1] = bus.in_valid && in_ready &&  bus.in_sel;
  assign valid[0] = (count[0] != '0);
  assign valid[1] = (count[1] != '0);
  assign pop[0] = valid[0] && bus.a_ready;
  assign pop[1] = valid[1] && bus.b_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        wr_ptr[d] <= '0;
        rd_ptr[d] <= '0;
        count[d]  <= '0;
        for (int e = 0; e < DEPTH; e++) begin
          mem[d][e] <= '0;
        end
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (push[d]) begin
          mem[d][wr_ptr[d]] <= bus.in_data;
          wr_ptr[d]         <= wr_ptr[d] + PW'(1);
        end
        if (pop[d]) begin
          rd_ptr[d] <= rd_ptr[d] + PW'(1);
        end
        count[d] <= count[d] + CW'(push[d]) - CW'(pop[d]);
      end
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.a_valid  = valid[0];
  assign bus.b_valid  = valid[1];
  assign bus.a_data   = mem[0][rd_ptr[0]];
  assign bus.b_data   = mem[1][rd_ptr[1]];
  assign bus.a_count  = count[0];
  assign bus.b_count  = count[1];
endmodule
